commit_unit: RTL

In-order retirement controller for the reorder buffer (ROB). Each cycle it inspects the ROB head and retires at most one entry. ALU and load results are written to the register file. Stores are authorised to the store buffer through a valid/ready handshake. A mispredicted branch triggers a multi-cycle pipeline flush with a redirect PC. The block drives the ROB dequeue strobe and sits between the ROB, the register file/RAT, the store buffer and the fetch unit.

---
 rtl/commit_unit_pkg.sv | 32 +++
 rtl/commit_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the ROB commit unit.
//
// Contents:
//   CU_XLEN        default datapath width used by the ROB entry payload
//   ITYPE_*        instruction-class encodings carried in ROB_entry_t.itype
//   ROB_entry_t    packed ROB head entry as seen by the commit unit
//   commit_state_t retirement controller states
package commit_unit_pkg;

    localparam int CU_XLEN = 32;

    localparam logic [1:0] ITYPE_BRANCH = 2'b00;
    localparam logic [1:0] ITYPE_STORE  = 2'b01;
    localparam logic [1:0] ITYPE_ALU    = 2'b10;
    localparam logic [1:0] ITYPE_LOAD   = 2'b11;

    // branch_result = 1 marks a mispredicted branch whose target PC is in value.
    typedef struct packed {
        logic [1:0]         itype;
        logic [3:0]         ROB_number;
        logic [4:0]         dest_reg;
        logic [CU_XLEN-1:0] value;
        logic               branch_result;
    } ROB_entry_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } commit_state_t;

endpackage

// File: rtl/commit_unit.sv
// In-order retirement controller sitting on the ROB head.
//
// Retires at most one entry per cycle: ALU/LOAD results go to the register
// file, stores are authorised to the store buffer through a valid/ready
// handshake, and a mispredicted branch starts a FLUSH_CYCLES-long flush with
// a registered redirect PC.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   head                ROB head entry
//   head_valid/ready    ROB non-empty / head result present
//   rd_en               dequeue the ROB head this cycle
//   rf_we/waddr/wdata   register-file write port
//   rf_wrob             ROB number of the retiring ALU/LOAD entry (RAT clear)
//   st_commit_valid/rob store authorisation to the store buffer
//   st_commit_ready     store buffer accepted the authorisation
//   flush, redirect_pc  pipeline squash and fetch restart address (registered)
//   retired_count       free-running count of retired instructions
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = CU_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  ROB_entry_t      head,
    input  logic            head_valid,
    input  logic            head_ready,
    output logic            rd_en,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [3:0]      rf_wrob,
    output logic            st_commit_valid,
    output logic [3:0]      st_commit_rob,
    input  logic            st_commit_ready,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     retired_count
);

    commit_state_t   state_q, state_d;
    logic [3:0]      flushCnt_q, flushCnt_d;
    logic [XLEN-1:0] redirectPc_q, redirectPc_d;
    logic            flush_q, flush_d;
    logic [3:0]      storeRob_q, storeRob_d;
    logic [31:0]     retiredCount_q, retiredCount_d;

    logic            rdEn, rfWe, stValid;
    logic [4:0]      rfWaddr;
    logic [XLEN-1:0] rfWdata;
    logic [3:0]      rfWrob, stRob;
    logic            retireable;

    assign retireable = head_valid && head_ready;

    // Next-state and Mealy strobe decode from the registered state and the
    // current head. The store's ROB number is captured on entry to STORE_WAIT
    // so st_commit_rob stays stable for the whole handshake.
    always_comb begin
        state_d      = state_q;
        flushCnt_d   = flushCnt_q;
        redirectPc_d = redirectPc_q;
        flush_d      = flush_q;
        storeRob_d   = storeRob_q;
        rdEn         = 1'b0;
        rfWe         = 1'b0;
        rfWaddr      = '0;
        rfWdata      = '0;
        rfWrob       = '0;
        stValid      = 1'b0;
        stRob        = '0;

        case (state_q)
            RUN: begin
                if (retireable) begin
                    case (head.itype)
                        ITYPE_ALU, ITYPE_LOAD: begin
                            rdEn    = 1'b1;
                            rfWe    = (head.dest_reg != 5'd0);
                            rfWaddr = head.dest_reg;
                            rfWdata = head.value;
                            rfWrob  = head.ROB_number;
                        end
                        ITYPE_STORE: begin
                            stValid    = 1'b1;
                            stRob      = head.ROB_number;
                            storeRob_d = head.ROB_number;
                            if (st_commit_ready) begin
                                rdEn = 1'b1;
                            end else begin
                                state_d = STORE_WAIT;
                            end
                        end
                        default: begin
                            rdEn = 1'b1;
                            if (head.branch_result) begin
                                redirectPc_d = head.value;
                                flushCnt_d   = 4'(FLUSH_CYCLES);
                                flush_d      = 1'b1;
                                state_d      = FLUSH;
                            end
                        end
                    endcase
                end
            end
            STORE_WAIT: begin
                stValid = 1'b1;
                stRob   = storeRob_q;
                if (st_commit_ready) begin
                    rdEn    = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // The counter value 1 marks the last flush cycle.
                if (flushCnt_q <= 4'd1) begin
                    flush_d = 1'b0;
                    state_d = RUN;
                end else begin
                    flushCnt_d = flushCnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        retiredCount_d = retiredCount_q + {31'd0, rdEn};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            flushCnt_q     <= '0;
            redirectPc_q   <= '0;
            flush_q        <= 1'b0;
            storeRob_q     <= '0;
            retiredCount_q <= '0;
        end else begin
            state_q        <= state_d;
            flushCnt_q     <= flushCnt_d;
            redirectPc_q   <= redirectPc_d;
            flush_q        <= flush_d;
            storeRob_q     <= storeRob_d;
            retiredCount_q <= retiredCount_d;
        end
    end

    // The Mealy strobes are gated by reset so that every output drops to zero
    // as soon as reset is asserted, not just at the next clock edge.
    assign rd_en           = rdEn && reset;
    assign rf_we           = rfWe && reset;
    assign rf_waddr        = reset ? rfWaddr : '0;
    assign rf_wdata        = reset ? rfWdata : '0;
    assign rf_wrob         = reset ? rfWrob  : '0;
    assign st_commit_valid = stValid && reset;
    assign st_commit_rob   = reset ? stRob   : '0;
    assign flush           = flush_q;
    assign redirect_pc     = redirectPc_q;
    assign retired_count   = retiredCount_q;

endmodule
